// File: rtl/regfile_bist.sv
// regfile_bist: parameterised 2R/1W register file with a built-in March-style self-test.
//
// Parameters
//   WIDTH    data width
//   AWIDTH   address width, DEPTH = 2**AWIDTH
//   ZERO_REG 1: register 0 reads 0 and drops writes
//   BYPASS   1: a same-cycle functional write is forwarded to a matching read port
//
// Ports
//   Clk, ResetN                   clock, async active-low reset (clears array and BIST state)
//   ReadRegister1/2 -> ReadData1/2 combinational read ports
//   WriteRegister, WriteData, RegWrite  functional write port (ignored while BistBusy)
//   BistStart                     start a self-test run (accepted in IDLE or DONE)
//   BistBusy, BistDone            run in progress / result valid
//   BistPass, BistFailAddr        result: no mismatch / first failing address

// One storage word. HARDZERO cells never load, so they hold their reset value of 0.
module regfile_cell #(
  parameter int WIDTH    = 32,
  parameter bit HARDZERO = 1'b0
)(
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)                q_q <= '0;
    else if (we_i && !HARDZERO) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module regfile_bist #(
  parameter int WIDTH    = 32,
  parameter int AWIDTH   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
)(
  input  logic              Clk,
  input  logic              ResetN,
  input  logic [AWIDTH-1:0] ReadRegister1,
  input  logic [AWIDTH-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic [AWIDTH-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic              BistStart,
  output logic              BistBusy,
  output logic              BistDone,
  output logic              BistPass,
  output logic [AWIDTH-1:0] BistFailAddr
);
  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH-1);

  typedef enum logic [2:0] {S_IDLE, S_W0, S_R0W1, S_R1W0, S_R0, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              pass_q, pass_d;
  logic [AWIDTH-1:0] fail_q, fail_d;

  logic                        busy;
  logic                        bist_we;
  logic [WIDTH-1:0]            bist_wdata;
  logic [WIDTH-1:0]            bist_exp;
  logic                        bist_cmp;
  logic [WIDTH-1:0]            bist_raw;
  logic [DEPTH-1:0]            cell_we;
  logic [WIDTH-1:0]            cell_d;
  logic [DEPTH-1:0][WIDTH-1:0] cell_q;

  assign busy = (state_q == S_W0) || (state_q == S_R0W1) ||
                (state_q == S_R1W0) || (state_q == S_R0);

  // ---------------- storage array ----------------
  // The BIST engine owns the write port while busy; functional writes are dropped.
  assign cell_d = busy ? bist_wdata : WriteData;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign cell_we[i] = busy ? (bist_we && (addr_q == AWIDTH'(i)))
                             : (RegWrite && (WriteRegister == AWIDTH'(i)));
    regfile_cell #(
      .WIDTH   (WIDTH),
      .HARDZERO((ZERO_REG != 0) && (i == 0))
    ) u_cell (
      .Clk   (Clk),
      .ResetN(ResetN),
      .we_i  (cell_we[i]),
      .d_i   (cell_d),
      .q_o   (cell_q[i])
    );
  end

  // ---------------- read ports ----------------
  // A write to a hardwired zero register is not forwarded: it never lands.
  logic fwd_ok;
  assign fwd_ok = (BYPASS != 0) && RegWrite && !busy &&
                  !((ZERO_REG != 0) && (WriteRegister == '0));

  assign ReadData1 = (fwd_ok && (WriteRegister == ReadRegister1)) ? WriteData
                                                                  : cell_q[ReadRegister1];
  assign ReadData2 = (fwd_ok && (WriteRegister == ReadRegister2)) ? WriteData
                                                                  : cell_q[ReadRegister2];

  // BIST always compares against the raw array, never the forwarded value.
  assign bist_raw = cell_q[addr_q];

  // ---------------- BIST FSM ----------------
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    bist_we    = 1'b0;
    bist_wdata = '0;
    bist_exp   = '0;
    bist_cmp   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (BistStart) begin
          state_d = S_W0;
          addr_d  = '0;
          pass_d  = 1'b1;
          fail_d  = '0;
        end
      end
      S_W0: begin
        bist_we = 1'b1;
        if (addr_q == LAST) begin
          state_d = S_R0W1;
          addr_d  = '0;
        end else addr_d = addr_q + 1'b1;
      end
      S_R0W1: begin
        bist_cmp   = 1'b1;
        bist_we    = 1'b1;
        bist_wdata = '1;
        if (addr_q == LAST) begin
          state_d = S_R1W0;
          addr_d  = LAST;
        end else addr_d = addr_q + 1'b1;
      end
      S_R1W0: begin
        bist_cmp = 1'b1;
        bist_we  = 1'b1;
        // A hardwired zero register cannot hold the ones pattern.
        bist_exp = ((ZERO_REG != 0) && (addr_q == '0)) ? '0 : '1;
        if (addr_q == '0) begin
          state_d = S_R0;
          addr_d  = '0;
        end else addr_d = addr_q - 1'b1;
      end
      S_R0: begin
        bist_cmp = 1'b1;
        if (addr_q == LAST) state_d = S_DONE;
        else                addr_d  = addr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // pass_q still high means no mismatch yet, so only the first one is latched.
    if (bist_cmp && (bist_raw != bist_exp) && pass_q) begin
      pass_d = 1'b0;
      fail_d = addr_q;
    end
  end

  assign BistBusy     = busy;
  assign BistDone     = (state_q == S_DONE);
  assign BistPass     = pass_q;
  assign BistFailAddr = fail_q;
endmodule

// File: tb/tb_regfile_bist.sv
module tb_regfile_bist;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        ResetN;
  logic [4:0]  rr1, rr2, wr, faddr;
  logic [31:0] wd, rd1, rd2;
  logic        we, bs, busy, done, pass;

  logic [2:0]  c_rr1, c_rr2, c_wr, c_faddr;
  logic [7:0]  c_wd, c_rd1, c_rd2;
  logic        c_we, c_bs, c_busy, c_done, c_pass;

  regfile_bist dut (
    .Clk(Clk), .ResetN(ResetN),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1), .ReadData2(rd2),
    .WriteRegister(wr), .WriteData(wd), .RegWrite(we),
    .BistStart(bs), .BistBusy(busy), .BistDone(done),
    .BistPass(pass), .BistFailAddr(faddr)
  );

  regfile_bist #(.WIDTH(8), .AWIDTH(3), .ZERO_REG(0), .BYPASS(0)) dut2 (
    .Clk(Clk), .ResetN(ResetN),
    .ReadRegister1(c_rr1), .ReadRegister2(c_rr2),
    .ReadData1(c_rd1), .ReadData2(c_rd2),
    .WriteRegister(c_wr), .WriteData(c_wd), .RegWrite(c_we),
    .BistStart(c_bs), .BistBusy(c_busy), .BistDone(c_done),
    .BistPass(c_pass), .BistFailAddr(c_faddr)
  );

  typedef struct {string tag; logic [63:0] val;} exp_t;
  exp_t sb[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;

  task automatic push(input string t, input logic [63:0] v);
    sb.push_back('{tag: t, val: v});
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    rr1 = '0; rr2 = '0; wr = '0; wd = '0; we = 1'b0; bs = 1'b0;
    c_rr1 = '0; c_rr2 = '0; c_wr = '0; c_wd = '0; c_we = 1'b0; c_bs = 1'b0;
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
  endtask

  // Called on the first negedge after the start edge; counts busy cycles of dut.
  task automatic bist_wait(input bit noise, output int cycles, output bit early);
    cycles = 0;
    early  = 1'b0;
    while (busy === 1'b1 && cycles < 1000) begin
      cycles++;
      if (done !== 1'b0) early = 1'b1;
      if (noise) begin
        we = 1'b1;
        wr = 5'($urandom);
        wd = $urandom;
      end
      @(negedge Clk);
    end
    we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 32; a++) begin
      rr1 = 5'(a);
      rr2 = 5'(31 - a);
      push("reset_read", 64'd0);
      #2;
      e = sb.pop_front(); vectors++;
      if ({rd1, rd2} !== e.val) begin
        miscompares++;
        $display("FAIL %s a=%0d got %h want %h", e.tag, a, {rd1, rd2}, e.val);
      end
      @(negedge Clk);
    end
    push("reset_flags", 64'd0);
    e = sb.pop_front(); vectors++;
    if ({busy, done, pass, faddr} !== e.val) begin
      miscompares++;
      $display("FAIL %s got %h want %h", e.tag, {busy, done, pass, faddr}, e.val);
    end
    push("reset_flags_alt", 64'd0);
    e = sb.pop_front(); vectors++;
    if ({c_busy, c_done, c_pass, c_faddr} !== e.val) begin
      miscompares++;
      $display("FAIL %s got %h want %h", e.tag, {c_busy, c_done, c_pass, c_faddr}, e.val);
    end
  endtask

  task automatic test_write_bypass();
    rr1 = 5'd2; rr2 = 5'd2; wr = 5'd2; wd = 32'd42; we = 1'b1;
    @(negedge Clk);
    we = 1'b0; wd = 32'd0;
    push("write_42", {32'd42, 32'd42});
    #2;
    e = sb.pop_front(); vectors++;
    if ({rd1, rd2} !== e.val) begin
      miscompares++; $display("FAIL %s got %h want %h", e.tag, {rd1, rd2}, e.val);
    end
    we = 1'b1; wd = 32'd15;
    push("bypass_15_before_edge", {32'd15, 32'd15});
    #2;
    e = sb.pop_front(); vectors++;
    if ({rd1, rd2} !== e.val) begin
      miscompares++; $display("FAIL %s got %h want %h", e.tag, {rd1, rd2}, e.val);
    end
    @(negedge Clk);
    we = 1'b0;
    push("bypass_15_after_edge", {32'd15, 32'd15});
    #2;
    e = sb.pop_front(); vectors++;
    if ({rd1, rd2} !== e.val) begin
      miscompares++; $display("FAIL %s got %h want %h", e.tag, {rd1, rd2}, e.val);
    end
  endtask

  task automatic test_write_isolation();
    logic [31:0] exp1 [5];
    logic [31:0] exp2 [5];
    string       tags [5];
    @(negedge Clk);
    rr1 = 5'd2; rr2 = 5'd3; wr = 5'd2; wd = 32'd10; we = 1'b1;
    exp1 = '{32'd10, 32'd10, 32'd10, 32'd0, 32'd0};
    exp2 = '{32'd0,  32'd0,  32'd5,  32'd5, 32'd5};
    tags = '{"noen_r2", "noen_r2_edge", "iso_r3", "r0_no_bypass", "r0_dropped"};
    for (int s = 0; s < 5; s++) begin
      @(negedge Clk);
      case (s)
        0: begin we = 1'b0; wd = 32'd5; end
        1: begin we = 1'b1; wr = 5'd3; wd = 32'd5; end
        2: begin we = 1'b0; end
        3: begin rr1 = 5'd0; wr = 5'd0; wd = 32'd10; we = 1'b1; end
        default: we = 1'b0;
      endcase
      // Step 1 arms the r3 write; the read after it is taken one edge later in step 2.
      push(tags[s], {exp1[s], exp2[s]});
      #2;
      e = sb.pop_front(); vectors++;
      if (s != 1 && {rd1, rd2} !== e.val) begin
        miscompares++; $display("FAIL %s got %h want %h", e.tag, {rd1, rd2}, e.val);
      end
      if (s == 1 && rd1 !== e.val[63:32]) begin
        miscompares++; $display("FAIL %s got %h want %h", e.tag, rd1, e.val[63:32]);
      end
    end
  endtask

  task automatic test_bist_pass();
    int cyc;
    bit early;
    @(negedge Clk);
    // Dirty a few registers so the post-run all-zero check is meaningful.
    for (int a = 1; a < 32; a += 5) begin
      we = 1'b1; wr = 5'(a); wd = 32'hDEAD_0000 | a;
      @(negedge Clk);
    end
    // Write coincident with the accepting edge still lands, then W0 clears it.
    bs = 1'b1; we = 1'b1; wr = 5'd9; wd = 32'h1234_5678;
    push("bist_busy_cycles", 64'd128);
    @(negedge Clk);
    bs = 1'b0; we = 1'b0;
    bist_wait(1'b1, cyc, early);
    e = sb.pop_front(); vectors++;
    if (64'(cyc) !== e.val) begin
      miscompares++; $display("FAIL %s got %0d want %0d", e.tag, cyc, e.val);
    end
    push("bist_done_low_while_busy", 64'd0);
    e = sb.pop_front(); vectors++;
    if (64'(early) !== e.val) begin
      miscompares++; $display("FAIL %s got %0d want %0d", e.tag, early, e.val);
    end
    push("bist_pass_flags", 64'b011);
    #2;
    e = sb.pop_front(); vectors++;
    if ({busy, done, pass} !== e.val) begin
      miscompares++; $display("FAIL %s got %b want %b", e.tag, {busy, done, pass}, e.val);
    end
    for (int a = 0; a < 32; a++) begin
      rr1 = 5'(a); rr2 = 5'(a);
      push("post_bist_zero", 64'd0);
      #2;
      e = sb.pop_front(); vectors++;
      if ({rd1, rd2} !== e.val) begin
        miscompares++; $display("FAIL %s a=%0d got %h want %h", e.tag, a, {rd1, rd2}, e.val);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_bist_fault();
    int cyc;
    bit early;
    // Bit 3 of word 7 pinned high (the rest of the word pinned low).
    force dut.g_cell[7].u_cell.q_q = 32'h0000_0008;
    for (int run = 0; run < 2; run++) begin
      if (run == 1) force dut.g_cell[20].u_cell.q_q = 32'h0000_0008;
      @(negedge Clk);
      bs = 1'b1;
      push("fault_busy_cycles", 64'd128);
      @(negedge Clk);
      bs = 1'b0;
      bist_wait(1'b0, cyc, early);
      e = sb.pop_front(); vectors++;
      if (64'(cyc) !== e.val || early !== 1'b0) begin
        miscompares++;
        $display("FAIL %s run=%0d got %0d early=%0d want %0d early=0", e.tag, run, cyc, early, e.val);
      end
      push("fault_result", {59'd0, 1'b1, 1'b0, 5'd7} >> 0);
      #2;
      e = sb.pop_front(); vectors++;
      if ({done, pass, faddr} !== e.val) begin
        miscompares++;
        $display("FAIL %s run=%0d got %b want %b", e.tag, run, {done, pass, faddr}, e.val);
      end
    end
    release dut.g_cell[7].u_cell.q_q;
    release dut.g_cell[20].u_cell.q_q;
    do_reset();
  endtask

  task automatic test_reset_mid_bist();
    rr1 = 5'd3; rr2 = 5'd0;
    bs = 1'b1;
    @(negedge Clk);
    bs = 1'b0;
    repeat (49) @(negedge Clk);
    // 32 W0 steps plus 17 R0W1 steps: r0..r16 now hold ones (r0 hardwired).
    push("mid_bist_state", {1'b1, 31'd0, 32'hFFFF_FFFF});
    #2;
    e = sb.pop_front(); vectors++;
    if ({busy, 31'd0, rd1} !== e.val || rd2 !== 32'd0) begin
      miscompares++; $display("FAIL %s got %b %h %h want %h", e.tag, busy, rd1, rd2, e.val);
    end
    ResetN = 1'b0;
    #1;
    push("mid_bist_reset", 64'd0);
    e = sb.pop_front(); vectors++;
    if ({busy, done, pass, faddr, rd1} !== e.val) begin
      miscompares++;
      $display("FAIL %s got %h want %h", e.tag, {busy, done, pass, faddr, rd1}, e.val);
    end
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_alt_params();
    int cyc;
    c_rr1 = 3'd0; c_rr2 = 3'd0; c_wr = 3'd0; c_wd = 8'hA5; c_we = 1'b1;
    push("alt_r0_before_edge", 64'd0);
    #2;
    e = sb.pop_front(); vectors++;
    if (c_rd1 !== e.val[7:0]) begin
      miscompares++; $display("FAIL %s got %h want %h", e.tag, c_rd1, e.val[7:0]);
    end
    @(negedge Clk);
    c_we = 1'b0;
    push("alt_r0_after_edge", 64'hA5A5);
    #2;
    e = sb.pop_front(); vectors++;
    if ({c_rd1, c_rd2} !== e.val[15:0]) begin
      miscompares++; $display("FAIL %s got %h want %h", e.tag, {c_rd1, c_rd2}, e.val[15:0]);
    end
    @(negedge Clk);
    c_bs = 1'b1;
    push("alt_bist_cycles", 64'd32);
    @(negedge Clk);
    c_bs = 1'b0;
    cyc = 0;
    while (c_busy === 1'b1 && cyc < 1000) begin
      cyc++;
      @(negedge Clk);
    end
    e = sb.pop_front(); vectors++;
    if (64'(cyc) !== e.val) begin
      miscompares++; $display("FAIL %s got %0d want %0d", e.tag, cyc, e.val);
    end
    push("alt_bist_result", 64'b011);
    #2;
    e = sb.pop_front(); vectors++;
    if ({c_busy, c_done, c_pass} !== e.val) begin
      miscompares++; $display("FAIL %s got %b want %b", e.tag, {c_busy, c_done, c_pass}, e.val);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_write_isolation();
    test_bist_pass();
    test_bist_fault();
    test_reset_mid_bist();
    test_alt_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (vectors=%0d)", vectors);
    $fatal(1, "watchdog");
  end
endmodule
